// File: rtl/z80_tb_pkg.sv
// Shared types for the Z80 bus memory responder: FSM states, bus-cycle record, counter helpers.
package z80_tb_pkg;

    localparam int unsigned CNT_W      = 32;
    localparam int unsigned BUS_ADDR_W = 16;
    localparam int unsigned BUS_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        XFER,
        HOLD
    } state_e;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] data;
        logic                  is_write;
        logic                  is_fetch;
    } bus_cycle_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/z80_bus_mem_responder_if.sv
// Z80 memory-bus signal bundle; master is the CPU side, slave the memory responder.
interface z80_bus_mem_responder_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic              MREQ;
    logic              RD;
    logic              WR;
    logic              RFSH;
    logic              M1;
    logic [ADDR_W-1:0] ADDRESS_BUS;
    logic [DATA_W-1:0] DATA_BUS_O;
    logic [DATA_W-1:0] DATA_BUS_I;
    logic              WAIT_N;

    modport master (
        output MREQ, RD, WR, RFSH, M1, ADDRESS_BUS, DATA_BUS_O,
        input  DATA_BUS_I, WAIT_N
    );

    modport slave (
        input  MREQ, RD, WR, RFSH, M1, ADDRESS_BUS, DATA_BUS_O,
        output DATA_BUS_I, WAIT_N
    );
endinterface

// File: rtl/z80_sync_ram.sv
// Single-port-write, registered-read RAM; contents are never reset.
module z80_sync_ram #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 65536
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Read and write in the same edge: the read sees the old contents.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/z80_bus_mem_responder.sv
// Z80 bus memory responder: decodes MREQ/RD/WR cycles, inserts wait states, serves an internal
// RAM with a side-band preload port, and reports access counts and bus errors.
module z80_bus_mem_responder
    import z80_tb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MEM_DEPTH  = 65536,
    parameter int unsigned MAX_WAIT   = 7,
    parameter logic [DATA_W-1:0] FILL_VALUE = 8'hFF,
    localparam int unsigned CFG_W     = $clog2(MAX_WAIT + 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    z80_bus_mem_responder_if.slave bus,
    input  logic [CFG_W-1:0]  WAIT_CFG,
    input  logic              LOAD_EN,
    input  logic [ADDR_W-1:0] LOAD_ADDR,
    input  logic [DATA_W-1:0] LOAD_DATA,
    output logic [CNT_W-1:0]  RD_CNT,
    output logic [CNT_W-1:0]  WR_CNT,
    output logic [CNT_W-1:0]  FETCH_CNT,
    output logic              OOR_ERR,
    output logic              PROT_ERR
);

    localparam int unsigned RAM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [CFG_W-1:0] MAX_W = CFG_W'(MAX_WAIT);

    state_e            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_is_write;
    logic              r_is_fetch;
    logic              r_prot_block;
    logic [CFG_W-1:0]  r_wait_cnt;
    logic              r_wait_n;
    logic              r_oor_err;
    logic              r_prot_err;
    logic [CNT_W-1:0]  r_rd_cnt;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic [CNT_W-1:0]  r_fetch_cnt;

    logic              w_start;
    logic              w_prot;
    logic [CFG_W-1:0]  w_cfg;
    logic              w_bus_oor;
    logic              w_cur_oor;
    logic              w_load_oor;
    logic              w_stall;
    logic              w_done;
    logic              w_strobe;
    logic              w_cpu_we;
    logic              w_load_we;
    logic              w_ram_we;
    logic [RAM_AW-1:0] w_ram_waddr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic              w_ram_re;
    logic [DATA_W-1:0] w_ram_rdata;
    logic [DATA_W-1:0] w_data_out;

    assign w_prot     = bus.MREQ & ~bus.RFSH & bus.RD & bus.WR;
    assign w_start    = bus.MREQ & ~bus.RFSH & (bus.RD ^ bus.WR) & ~r_prot_block;
    assign w_cfg      = (WAIT_CFG > MAX_W) ? MAX_W : WAIT_CFG;
    assign w_bus_oor  = 32'(bus.ADDRESS_BUS) >= MEM_DEPTH;
    assign w_cur_oor  = 32'(r_addr) >= MEM_DEPTH;
    assign w_load_oor = 32'(LOAD_ADDR) >= MEM_DEPTH;
    assign w_strobe   = r_is_write ? bus.WR : bus.RD;

    // A preload owns the single RAM write port; a CPU write in XFER yields to it.
    assign w_stall     = (r_state == XFER) & r_is_write & LOAD_EN;
    assign w_done      = (r_state == XFER) & ~w_stall;
    assign w_cpu_we    = w_done & r_is_write & ~w_cur_oor;
    assign w_load_we   = LOAD_EN & ~w_load_oor;
    assign w_ram_we    = w_load_we | w_cpu_we;
    assign w_ram_waddr = w_load_we ? LOAD_ADDR[RAM_AW-1:0] : r_addr[RAM_AW-1:0];
    assign w_ram_wdata = w_load_we ? LOAD_DATA : bus.DATA_BUS_O;
    assign w_ram_re    = (r_state == XFER) & ~r_is_write;

    z80_sync_ram #(
        .ADDR_W (RAM_AW),
        .DATA_W (DATA_W),
        .DEPTH  (MEM_DEPTH)
    ) u_ram (
        .i_clk   (CLK),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_ram_re),
        .i_raddr (r_addr[RAM_AW-1:0]),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_is_write   <= 1'b0;
            r_is_fetch   <= 1'b0;
            r_prot_block <= 1'b0;
            r_wait_cnt   <= '0;
            r_wait_n     <= 1'b1;
            r_oor_err    <= 1'b0;
            r_prot_err   <= 1'b0;
            r_rd_cnt     <= '0;
            r_wr_cnt     <= '0;
            r_fetch_cnt  <= '0;
        end else begin
            r_oor_err  <= 1'b0;
            r_prot_err <= 1'b0;
            if (!bus.MREQ) begin
                r_prot_block <= 1'b0;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_prot && !r_prot_block) begin
                        r_prot_err   <= 1'b1;
                        r_prot_block <= 1'b1;
                    end else if (w_start) begin
                        r_addr     <= bus.ADDRESS_BUS;
                        r_is_write <= bus.WR;
                        r_is_fetch <= bus.M1;
                        if (w_cfg != '0) begin
                            r_state    <= WAIT;
                            r_wait_cnt <= w_cfg;
                            r_wait_n   <= 1'b0;
                        end else begin
                            r_state   <= XFER;
                            r_oor_err <= w_bus_oor;
                        end
                    end
                end
                WAIT: begin
                    if (r_wait_cnt == CFG_W'(1)) begin
                        r_state   <= XFER;
                        r_wait_n  <= 1'b1;
                        r_oor_err <= w_cur_oor;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - CFG_W'(1);
                    end
                end
                XFER: begin
                    if (w_stall) begin
                        r_wait_n <= 1'b0;
                    end else begin
                        r_wait_n <= 1'b1;
                        r_state  <= HOLD;
                        if (r_is_write) begin
                            r_wr_cnt <= sat_inc(r_wr_cnt);
                        end else begin
                            r_rd_cnt <= sat_inc(r_rd_cnt);
                            if (r_is_fetch) begin
                                r_fetch_cnt <= sat_inc(r_fetch_cnt);
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!bus.MREQ || !w_strobe) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_data_out = '0;
        if (r_state == HOLD && !r_is_write) begin
            w_data_out = w_cur_oor ? FILL_VALUE : w_ram_rdata;
        end
    end

    assign bus.DATA_BUS_I = w_data_out;
    assign bus.WAIT_N     = r_wait_n;
    assign RD_CNT         = r_rd_cnt;
    assign WR_CNT         = r_wr_cnt;
    assign FETCH_CNT      = r_fetch_cnt;
    assign OOR_ERR        = r_oor_err;
    assign PROT_ERR       = r_prot_err;

endmodule

// File: doc/z80_bus_mem_responder.md
Name: z80_bus_mem_responder

Overview:
Parametrised, synthesizable memory responder for the Z80 CPU bus. It replaces the hand-driven data and WAIT_N stimulus in the CPU test bench. It decodes MREQ/RD/WR/RFSH cycles from z80_top, serves reads and commits writes against an internal array, inserts a runtime-programmable number of wait states, and accepts a side-band preload port so tests can load programs. Access counters and error pulses feed bench scoreboards.

Parameters:
ADDR_W, 16, address bus width
DATA_W, 8, data bus width
MEM_DEPTH, 65536, implemented words; addresses >= MEM_DEPTH are out of range
MAX_WAIT, 7, largest wait-state count accepted on WAIT_CFG
FILL_VALUE, 8'hFF, read data returned for out-of-range addresses

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
MREQ  in  1  memory request from CPU, active-high
RD  in  1  read strobe, active-high
WR  in  1  write strobe, active-high
RFSH  in  1  refresh cycle flag; MREQ with RFSH is ignored
M1  in  1  opcode-fetch flag
ADDRESS_BUS  in  ADDR_W  CPU address
DATA_BUS_O  in  DATA_W  CPU write data
DATA_BUS_I  out  DATA_W  read data to CPU
WAIT_N  out  1  wait request to CPU, active-low
WAIT_CFG  in  $clog2(MAX_WAIT+1)  wait states per access; sampled at access start; values > MAX_WAIT clamp to MAX_WAIT
LOAD_EN  in  1  preload write strobe
LOAD_ADDR  in  ADDR_W  preload address
LOAD_DATA  in  DATA_W  preload data
RD_CNT  out  32  completed reads, saturating
WR_CNT  out  32  completed writes, saturating
FETCH_CNT  out  32  completed reads with M1=1, saturating
OOR_ERR  out  1  one-cycle pulse on an out-of-range access
PROT_ERR  out  1  one-cycle pulse when RD and WR are both high with MREQ

Behaviour:
- Reset values: DATA_BUS_I=0, WAIT_N=1, all counters 0, OOR_ERR=0, PROT_ERR=0, state IDLE. Reset does not clear memory contents. Reset mid-access returns to IDLE immediately and abandons the access; no write commits.
- Access start: the first CLK edge in IDLE where MREQ=1, RFSH=0 and exactly one of RD/WR is high. At that edge ADDRESS_BUS, M1, direction and the clamped WAIT_CFG (w) are latched.
- MREQ with RD=WR=1: PROT_ERR pulses the next cycle; no access; state remains IDLE until MREQ drops.
- States and transitions:
  - IDLE -> WAIT when w>0; IDLE -> XFER when w=0.
  - WAIT: WAIT_N=0 (registered) for exactly w cycles, then -> XFER.
  - XFER: one cycle. A read registers mem[addr] (or FILL_VALUE) onto DATA_BUS_I. A write samples DATA_BUS_O at this edge and commits it. Counters update at this edge. -> HOLD.
  - HOLD: DATA_BUS_I holds the read data until MREQ or the active strobe falls, then -> IDLE with DATA_BUS_I=0.
- Latency: with w=0, read data is valid 2 edges after the start edge. Each wait state adds 1 cycle. WAIT_N rises on the same edge XFER is entered.
- Out-of-range (addr >= MEM_DEPTH): reads return FILL_VALUE and writes are dropped. OOR_ERR pulses in the XFER cycle. Counters still increment.
- Preload: LOAD_EN writes LOAD_DATA to LOAD_ADDR on the edge it is sampled, in any state. If a CPU write reaches XFER in the same cycle, the CPU write stalls in XFER one extra cycle with WAIT_N forced 0, then commits.
- Read of LOAD_ADDR in the same XFER cycle as a preload returns the old data (read-before-write).
- Counters saturate at 32'hFFFF_FFFF; no wrap.

Decomposition:
- Shared package z80_tb_pkg holds:
  - the state enum (IDLE, WAIT, XFER, HOLD)
  - a bus-cycle struct {addr, data, is_write, is_fetch}
  - counter width localparam CNT_W=32
- One sub-module z80_sync_ram (single clocked write port, registered read port, parametrised ADDR_W/DATA_W/DEPTH). The responder FSM, wait counter, error logic and counters stay in the top.

Test Plan:
- Preload 0x0000=0x3E and 0x0001=0x55 via LOAD_EN; fetch read (M1=1, MREQ, RD) at 0x0000 with WAIT_CFG=0 -> WAIT_N stays 1, DATA_BUS_I=0x3E two edges after start, FETCH_CNT=1, RD_CNT=1.
- WAIT_CFG=3; write 0xA5 to 0x1234, then read 0x1234 -> WAIT_N low exactly 3 cycles per access, read returns 0xA5, WR_CNT=1.
- MEM_DEPTH=4096; read 0x2000 -> DATA_BUS_I=0xFF and OOR_ERR pulses once; write 0x2000=0x11 then a preload-free readback of 0x0000 is unchanged.
- RFSH=1 with MREQ=1, RD=1 -> no response, counters unchanged. MREQ=RD=WR=1 -> PROT_ERR pulses once, no memory change.
- Assert RESET during the 2nd wait state of a write to 0x0010 (old value 0x77) -> WAIT_N=1 within the reset assertion, 0x0010 still reads 0x77, counters 0.
- LOAD_EN to 0x0020=0x99 coinciding with the XFER of a CPU write 0x0021=0x42 -> WAIT_N extended 1 cycle, both locations hold their values.
